regfile_alu_pipe: RTL and testbench

Parametrised two-stage register-file/ALU execute datapath for the processor core. It supersedes the single-register-file, fixed-width execute block. It adds:
- valid-qualified issue,
- a registered execute stage with same-cycle writeback,
- operand forwarding for back-to-back dependent operations,
- a persistent flags register,
- a combinational debug read port.

The controller/decoder sits upstream and issues at most one operation per cycle.

---
 rtl/regfile_alu_pipe.sv | 206 ++++++++++++++++++++
 tb/tb_regfile_alu_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_alu_pipe.sv
// regfile_alu_pipe
// Two-stage register-file / ALU execute datapath.
//   Stage 1 captures the opcode, destination and both operands at the issue
//   edge. Stage 2 evaluates the ALU combinationally from the captured operands
//   and commits the register write, flags and AluOutput at the next edge.
//   Operand reads at issue are forwarded from the stage-2 result when stage 2
//   is writing the same register, so dependent ops need no bubble.
// Ports:
//   Clk          rising-edge clock
//   Rst          asynchronous active-low reset
//   In_valid     operation present this cycle
//   OpCode       5-bit operation select
//   RdestRegLoc  destination / first operand register
//   RsrcRegLoc   source register (second operand when Imm_s = 0)
//   Imm_s        1 = second operand is Imm
//   Imm          immediate operand, already extended
//   DbgAddr      debug read address
//   Out_valid    AluOutput/Flags reflect an op completed at the last edge
//   AluOutput    registered result of the last completed op
//   Flags        registered {C, L, F, Z, N}
//   DbgData      combinational architectural register[DbgAddr]
module regfile_alu_pipe #(
  parameter  int WIDTH = 16,
  parameter  int NREGS = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             In_valid,
  input  logic [4:0]       OpCode,
  input  logic [AW-1:0]    RdestRegLoc,
  input  logic [AW-1:0]    RsrcRegLoc,
  input  logic             Imm_s,
  input  logic [WIDTH-1:0] Imm,
  input  logic [AW-1:0]    DbgAddr,
  output logic             Out_valid,
  output logic [WIDTH-1:0] AluOutput,
  output logic [4:0]       Flags,
  output logic [WIDTH-1:0] DbgData
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [4:0] OP_MOV = 5'b00000;
  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_CMP = 5'b00011;
  localparam logic [4:0] OP_AND = 5'b00100;
  localparam logic [4:0] OP_OR  = 5'b00101;
  localparam logic [4:0] OP_XOR = 5'b00110;
  localparam logic [4:0] OP_LSH = 5'b00111;
  localparam logic [4:0] OP_RSH = 5'b01000;

  // Flag bit positions within {C, L, F, Z, N}
  localparam int FC = 4;
  localparam int FL = 3;
  localparam int FF = 2;
  localparam int FZ = 1;
  localparam int FN = 0;

  logic [WIDTH-1:0] regs_q [NREGS];

  logic             s1_valid_q;
  logic [4:0]       s1_op_q;
  logic [AW-1:0]    s1_dest_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] alu_out_q;
  logic [4:0]       flags_q;

  logic [WIDTH-1:0] alu_res_d;
  logic [4:0]       flags_d;
  logic             alu_wr;
  logic             zn_upd;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             wr_en;

  logic [WIDTH-1:0] op_a_d;
  logic [WIDTH-1:0] op_b_reg;
  logic [WIDTH-1:0] op_b_d;

  // Stage 2: ALU on captured operands
  always_comb begin
    alu_res_d = s1_a_q;
    flags_d   = flags_q;
    alu_wr    = 1'b0;
    zn_upd    = 1'b0;
    sum       = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    diff      = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    case (s1_op_q)
      OP_MOV: begin
        alu_res_d = s1_b_q;
        alu_wr    = 1'b1;
      end
      OP_ADD: begin
        alu_res_d   = sum[WIDTH-1:0];
        alu_wr      = 1'b1;
        zn_upd      = 1'b1;
        flags_d[FC] = sum[WIDTH];
        flags_d[FF] = (s1_a_q[MSB] == s1_b_q[MSB]) && (sum[MSB] != s1_a_q[MSB]);
      end
      OP_SUB: begin
        alu_res_d   = diff[WIDTH-1:0];
        alu_wr      = 1'b1;
        zn_upd      = 1'b1;
        // The extra top bit of the WIDTH+1 difference is the borrow.
        flags_d[FC] = diff[WIDTH];
        flags_d[FF] = (s1_a_q[MSB] != s1_b_q[MSB]) && (diff[MSB] != s1_a_q[MSB]);
      end
      OP_CMP: begin
        flags_d[FL] = s1_a_q < s1_b_q;
        flags_d[FN] = $signed(s1_a_q) < $signed(s1_b_q);
        flags_d[FZ] = s1_a_q == s1_b_q;
      end
      OP_AND: begin
        alu_res_d = s1_a_q & s1_b_q;
        alu_wr    = 1'b1;
        zn_upd    = 1'b1;
      end
      OP_OR: begin
        alu_res_d = s1_a_q | s1_b_q;
        alu_wr    = 1'b1;
        zn_upd    = 1'b1;
      end
      OP_XOR: begin
        alu_res_d = s1_a_q ^ s1_b_q;
        alu_wr    = 1'b1;
        zn_upd    = 1'b1;
      end
      OP_LSH: begin
        alu_res_d = s1_a_q << s1_b_q[SHW-1:0];
        alu_wr    = 1'b1;
        zn_upd    = 1'b1;
      end
      OP_RSH: begin
        alu_res_d = s1_a_q >> s1_b_q[SHW-1:0];
        alu_wr    = 1'b1;
        zn_upd    = 1'b1;
      end
      default: ;
    endcase
    if (zn_upd) begin
      flags_d[FZ] = (alu_res_d == '0);
      flags_d[FN] = alu_res_d[MSB];
    end
  end

  assign wr_en = s1_valid_q && alu_wr;

  // Operand read with bypass from the stage-2 result being written this edge.
  always_comb begin
    op_a_d   = (wr_en && (s1_dest_q == RdestRegLoc)) ? alu_res_d : regs_q[RdestRegLoc];
    op_b_reg = (wr_en && (s1_dest_q == RsrcRegLoc))  ? alu_res_d : regs_q[RsrcRegLoc];
    op_b_d   = Imm_s ? Imm : op_b_reg;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_dest_q  <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      s1_valid_q <= In_valid;
      if (In_valid) begin
        s1_op_q   <= OpCode;
        s1_dest_q <= RdestRegLoc;
        s1_a_q    <= op_a_d;
        s1_b_q    <= op_b_d;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        alu_out_q <= alu_res_d;
        flags_q   <= flags_d;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[s1_dest_q] <= alu_res_d;
    end
  end

  assign Out_valid = out_valid_q;
  assign AluOutput = alu_out_q;
  assign Flags     = flags_q;
  assign DbgData   = regs_q[DbgAddr];

endmodule

// File: tb/tb_regfile_alu_pipe.sv
// Scoreboard bench for regfile_alu_pipe: one instance at WIDTH=16/NREGS=16
// and one at WIDTH=32/NREGS=8. Issue pushes the hand-computed result, flags
// and completion cycle; per-instance monitors pop on Out_valid.
module tb_regfile_alu_pipe;

  typedef struct {
    int          cyc;
    logic [31:0] res;
    logic [4:0]  flg;
  } exp_t;

  localparam logic [4:0] MOV = 5'b00000;
  localparam logic [4:0] ADD = 5'b00001;
  localparam logic [4:0] SUB = 5'b00010;
  localparam logic [4:0] CMP = 5'b00011;
  localparam logic [4:0] AND = 5'b00100;
  localparam logic [4:0] LSH = 5'b00111;
  localparam logic [4:0] RSH = 5'b01000;
  localparam logic [4:0] NOP = 5'b11111;

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t ea;
  exp_t eb;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  logic        a_valid = 0, a_ims = 0;
  logic [4:0]  a_op = '0;
  logic [3:0]  a_rd = '0, a_rs = '0, a_dbg = '0;
  logic [15:0] a_imm = '0;
  logic        a_ov;
  logic [15:0] a_alu, a_dbgd;
  logic [4:0]  a_flg;

  logic        b_valid = 0, b_ims = 0;
  logic [4:0]  b_op = '0;
  logic [2:0]  b_rd = '0, b_rs = '0, b_dbg = '0;
  logic [31:0] b_imm = '0;
  logic        b_ov;
  logic [31:0] b_alu, b_dbgd;
  logic [4:0]  b_flg;

  regfile_alu_pipe #(.WIDTH(16), .NREGS(16)) dut_a (
    .Clk(Clk), .Rst(Rst), .In_valid(a_valid), .OpCode(a_op),
    .RdestRegLoc(a_rd), .RsrcRegLoc(a_rs), .Imm_s(a_ims), .Imm(a_imm),
    .DbgAddr(a_dbg), .Out_valid(a_ov), .AluOutput(a_alu), .Flags(a_flg),
    .DbgData(a_dbgd));

  regfile_alu_pipe #(.WIDTH(32), .NREGS(8)) dut_b (
    .Clk(Clk), .Rst(Rst), .In_valid(b_valid), .OpCode(b_op),
    .RdestRegLoc(b_rd), .RsrcRegLoc(b_rs), .Imm_s(b_ims), .Imm(b_imm),
    .DbgAddr(b_dbg), .Out_valid(b_ov), .AluOutput(b_alu), .Flags(b_flg),
    .DbgData(b_dbgd));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitors
  always @(negedge Clk) begin
    if (Rst) begin
      if (a_ov) begin
        n_vec++;
        if (sb_a.size() == 0) begin
          n_bad++;
          $display("FAIL a_unexpected_valid: Out_valid=1 at cycle %0d, want none", cyc);
        end else begin
          ea = sb_a.pop_front();
          if (a_alu !== ea.res[15:0] || a_flg !== ea.flg || cyc != ea.cyc) begin
            n_bad++;
            $display("FAIL a_result: got alu=0x%0h flags=%b cyc=%0d, want alu=0x%0h flags=%b cyc=%0d",
                     a_alu, a_flg, cyc, ea.res[15:0], ea.flg, ea.cyc);
          end
        end
      end else if (sb_a.size() != 0 && sb_a[0].cyc <= cyc) begin
        n_vec++;
        n_bad++;
        $display("FAIL a_missing_valid: Out_valid=0 at cycle %0d, want 1", cyc);
        sb_a.delete(0);
      end
    end
  end

  always @(negedge Clk) begin
    if (Rst) begin
      if (b_ov) begin
        n_vec++;
        if (sb_b.size() == 0) begin
          n_bad++;
          $display("FAIL b_unexpected_valid: Out_valid=1 at cycle %0d, want none", cyc);
        end else begin
          eb = sb_b.pop_front();
          if (b_alu !== eb.res || b_flg !== eb.flg || cyc != eb.cyc) begin
            n_bad++;
            $display("FAIL b_result: got alu=0x%0h flags=%b cyc=%0d, want alu=0x%0h flags=%b cyc=%0d",
                     b_alu, b_flg, cyc, eb.res, eb.flg, eb.cyc);
          end
        end
      end else if (sb_b.size() != 0 && sb_b[0].cyc <= cyc) begin
        n_vec++;
        n_bad++;
        $display("FAIL b_missing_valid: Out_valid=0 at cycle %0d, want 1", cyc);
        sb_b.delete(0);
      end
    end
  end

  task automatic issue(input bit sel, input logic [4:0] op, input int rd, input int rs,
                       input bit ims, input logic [31:0] imm,
                       input logic [31:0] res, input logic [4:0] fl);
    exp_t e;
    @(negedge Clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    e.cyc = cyc + 2;
    e.res = res;
    e.flg = fl;
    if (!sel) begin
      a_valid = 1'b1; a_op = op; a_rd = rd[3:0]; a_rs = rs[3:0];
      a_ims = ims; a_imm = imm[15:0];
      sb_a.push_back(e);
    end else begin
      b_valid = 1'b1; b_op = op; b_rd = rd[2:0]; b_rs = rs[2:0];
      b_ims = ims; b_imm = imm;
      sb_b.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge Clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic dbg(input bit sel, input int addr, input logic [31:0] exp, input string name);
    if (!sel) a_dbg = addr[3:0];
    else      b_dbg = addr[2:0];
    #1;
    check(name, sel ? b_dbgd : {16'h0, a_dbgd}, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish before 100000");
    $fatal(1);
  end

  initial begin
    #1 Rst = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_a_valid", {31'h0, a_ov}, 0);
    check("rst_a_flags", {27'h0, a_flg}, 0);
    check("rst_a_alu", {16'h0, a_alu}, 0);
    check("rst_b_valid", {31'h0, b_ov}, 0);
    check("rst_b_alu", b_alu, 0);
    Rst = 1'b1;

    // Immediate path and forwarding
    issue(0, MOV, 1, 0, 1, 32'h00FF, 32'h00FF, 5'b00000);
    issue(0, ADD, 1, 0, 1, 32'hFF01, 32'h0000, 5'b10010);
    issue(0, MOV, 2, 0, 1, 32'h0005, 32'h0005, 5'b10010);
    issue(0, ADD, 2, 2, 0, 32'h0000, 32'h000A, 5'b00000);
    issue(0, ADD, 3, 2, 0, 32'h0000, 32'h000A, 5'b00000);
    idle(); idle();
    dbg(0, 1, 32'h0000, "r1_after_add");
    dbg(0, 2, 32'h000A, "r2_fwd");
    dbg(0, 3, 32'h000A, "r3_fwd");

    // CMP and flag hold
    issue(0, MOV, 4, 0, 1, 32'h8000, 32'h8000, 5'b00000);
    issue(0, MOV, 5, 0, 1, 32'h0001, 32'h0001, 5'b00000);
    issue(0, MOV, 8, 0, 1, 32'h8000, 32'h8000, 5'b00000);
    issue(0, ADD, 8, 0, 1, 32'h8000, 32'h0000, 5'b10110);
    issue(0, CMP, 4, 5, 0, 32'h0000, 32'h8000, 5'b10101);
    issue(0, CMP, 5, 4, 0, 32'h0000, 32'h0001, 5'b11100);
    issue(0, AND, 5, 4, 0, 32'h0000, 32'h0000, 5'b11110);

    // Shifts and NOP
    issue(0, MOV, 6, 0, 1, 32'h0001, 32'h0001, 5'b11110);
    issue(0, LSH, 6, 0, 1, 32'h0013, 32'h0008, 5'b11100);
    issue(0, RSH, 6, 0, 1, 32'h0004, 32'h0000, 5'b11110);
    issue(0, NOP, 4, 0, 1, 32'hFFFF, 32'h8000, 5'b11110);
    idle(); idle();
    dbg(0, 4, 32'h8000, "r4_after_cmp_nop");
    dbg(0, 5, 32'h0000, "r5_and");
    dbg(0, 6, 32'h0000, "r6_rsh");
    dbg(0, 8, 32'h0000, "r8_add_ovf");

    // WIDTH=32, NREGS=8
    issue(1, SUB, 0, 0, 1, 32'h1, 32'hFFFF_FFFF, 5'b10001);
    for (int k = 0; k < 8; k++)
      issue(1, MOV, k, 0, 1, 32'h100 + k, 32'h100 + k, 5'b10001);
    idle(); idle();
    for (int k = 0; k < 8; k++) dbg(1, k, 32'h100 + k, "b_reg");
    repeat (3) begin
      idle();
      check("b_bubble_valid", {31'h0, b_ov}, 0);
      check("b_bubble_alu", b_alu, 32'h107);
      check("b_bubble_flags", {27'h0, b_flg}, 32'h11);
    end

    // Reset mid-stream: r10 is in stage 1 when reset hits
    issue(0, MOV, 9, 0, 1, 32'h1234, 32'h1234, 5'b11110);
    issue(0, MOV, 10, 0, 1, 32'h5555, 32'h5555, 5'b11110);
    @(negedge Clk);
    a_valid = 1'b0;
    #1 Rst = 1'b0;
    sb_a.delete();
    sb_b.delete();
    #2;
    check("mid_rst_valid", {31'h0, a_ov}, 0);
    check("mid_rst_flags", {27'h0, a_flg}, 0);
    check("mid_rst_alu", {16'h0, a_alu}, 0);
    for (int k = 0; k < 16; k++) dbg(0, k, 32'h0, "mid_rst_reg");
    @(negedge Clk);
    Rst = 1'b1;
    issue(0, MOV, 3, 0, 1, 32'h00AB, 32'h00AB, 5'b00000);
    idle(); idle();
    dbg(0, 3, 32'h00AB, "post_rst_r3");
    dbg(0, 10, 32'h0000, "post_rst_r10");

    for (int t = 0; t < 20 && (sb_a.size() != 0 || sb_b.size() != 0); t++) idle();
    n_vec++;
    if (sb_a.size() != 0 || sb_b.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d pending, want 0/0", sb_a.size(), sb_b.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
